// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the Y86-64 pipeline registers and the hazard/run control unit.
// The pipeline side (master) supplies stage icodes and status; the control unit (slave) returns stage controls and counters.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [3:0]       D_icode;
  logic [3:0]       E_icode;
  logic [3:0]       M_icode;
  logic [3:0]       W_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_dstM;
  logic             e_Cnd;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;

  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc_en;
  logic             running;
  logic             halted;
  logic [3:0]       final_stat;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mp_cnt;
  logic [1:0]       dbg_state;

  // Controls have no handshake: every output is valid on every cycle and is
  // consumed by the pipeline registers at the next rising clock edge.
  modport master (
    output start, D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB,
           E_dstM, e_Cnd, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           set_cc_en, running, halted, final_stat, cyc_cnt, ret_cnt,
           lu_cnt, mp_cnt, dbg_state
  );

  modport slave (
    input  start, D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB,
           E_dstM, e_Cnd, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           set_cc_en, running, halted, final_stat, cyc_cnt, ret_cnt,
           lu_cnt, mp_cnt, dbg_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: per-stage stall/bubble generation, CC update gating,
// IDLE/RUN/HALTED run state with latched final status, and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       final_stat_q;
  logic [CNT_W-1:0] cyc_q, ret_q, lu_q, mp_q;

  logic lu, rt, mp, mx, wx, ret_ev;
  logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, cc_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    lu = ((bus.E_icode == 4'h5) || (bus.E_icode == 4'hB)) && (bus.E_dstM != 4'hF) &&
         ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    rt = (bus.D_icode == 4'h9) || (bus.E_icode == 4'h9) || (bus.M_icode == 4'h9);
    mp = (bus.E_icode == 4'h7) && !bus.e_Cnd;
    mx = (bus.m_stat == 4'h2) || (bus.m_stat == 4'h3) || (bus.m_stat == 4'h4);
    wx = (bus.W_stat == 4'h2) || (bus.W_stat == 4'h3) || (bus.W_stat == 4'h4);
    ret_ev = (bus.W_stat == 4'h1) && (bus.W_icode != 4'h1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_stall  = 1'b0;
    cc_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        f_stall  = 1'b1;
        d_bubble = 1'b1;
        e_bubble = 1'b1;
        m_bubble = 1'b1;
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        // A load/use stall keeps the instruction in decode, so a pending RET must not bubble it away.
        f_stall  = lu | rt;
        d_stall  = lu;
        d_bubble = mp | (rt & ~lu);
        e_bubble = mp | lu;
        m_bubble = mx | wx;
        w_stall  = wx;
        cc_en    = (bus.E_icode == 4'h6) & ~mx & ~wx;
        if (wx) state_d = S_HALT;
      end
      S_HALT: begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        w_stall = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      final_stat_q <= 4'h1;
      cyc_q        <= '0;
      ret_q        <= '0;
      lu_q         <= '0;
      mp_q         <= '0;
    end else if (state_q == S_RUN) begin
      cyc_q <= sat_inc(cyc_q);
      if (ret_ev) ret_q <= sat_inc(ret_q);
      if (lu)     lu_q  <= sat_inc(lu_q);
      if (mp)     mp_q  <= sat_inc(mp_q);
      if (wx)     final_stat_q <= bus.W_stat;
    end
  end

  assign bus.F_stall    = f_stall;
  assign bus.D_stall    = d_stall;
  assign bus.D_bubble   = d_bubble;
  assign bus.E_bubble   = e_bubble;
  assign bus.M_bubble   = m_bubble;
  assign bus.W_stall    = w_stall;
  assign bus.set_cc_en  = cc_en;
  assign bus.running    = (state_q == S_RUN);
  assign bus.halted     = (state_q == S_HALT);
  assign bus.final_stat = final_stat_q;
  assign bus.cyc_cnt    = cyc_q;
  assign bus.ret_cnt    = ret_q;
  assign bus.lu_cnt     = lu_q;
  assign bus.mp_cnt     = mp_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl: a reference model predicts every cycle's controls and
// counters (32-bit and 4-bit counter instances); a negedge monitor pops the expectations and compares.
module tb_pipe_hazard_ctrl;
  localparam int W = 157;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  pipe_hazard_ctrl #(.CNT_W(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipe_hazard_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  assign bus4.start   = bus.start;
  assign bus4.D_icode = bus.D_icode;
  assign bus4.E_icode = bus.E_icode;
  assign bus4.M_icode = bus.M_icode;
  assign bus4.W_icode = bus.W_icode;
  assign bus4.d_srcA  = bus.d_srcA;
  assign bus4.d_srcB  = bus.d_srcB;
  assign bus4.E_dstM  = bus.E_dstM;
  assign bus4.e_Cnd   = bus.e_Cnd;
  assign bus4.m_stat  = bus.m_stat;
  assign bus4.W_stat  = bus.W_stat;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: run state as an int, counters as unbounded integers clipped when compared.
  int         m_st;
  longint     m_cyc, m_ret, m_lu, m_mp;
  logic [3:0] m_fin;

  function automatic logic [31:0] sat(input longint v, input int w);
    longint mx;
    mx = (64'd1 << w) - 1;
    return (v > mx) ? mx[31:0] : v[31:0];
  endfunction

  function automatic bit is_exc(input logic [3:0] s);
    return (s == 4'h2) || (s == 4'h3) || (s == 4'h4);
  endfunction

  function automatic bit h_lu();
    return (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_dstM != 4'hF &&
           (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
  endfunction

  function automatic bit h_rt();
    return bus.D_icode == 4'h9 || bus.E_icode == 4'h9 || bus.M_icode == 4'h9;
  endfunction

  function automatic bit h_mp();
    return bus.E_icode == 4'h7 && !bus.e_Cnd;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_fin = 4'h1;
    m_cyc = 0; m_ret = 0; m_lu = 0; m_mp = 0;
  endtask

  function automatic logic [W-1:0] predict();
    logic f, ds, db, eb, mb, ws, cc;
    logic [31:0] c, r, l, p, c4, r4, l4, p4;
    bit lu_h, rt_h, mp_h, mx_h, wx_h;
    lu_h = h_lu(); rt_h = h_rt(); mp_h = h_mp();
    mx_h = is_exc(bus.m_stat); wx_h = is_exc(bus.W_stat);
    {f, ds, db, eb, mb, ws, cc} = 7'b0;
    if (m_st == M_IDLE) begin
      f = 1; db = 1; eb = 1; mb = 1;
    end else if (m_st == M_HALT) begin
      f = 1; ds = 1; ws = 1;
    end else begin
      f  = lu_h || rt_h;
      ds = lu_h;
      db = mp_h || (rt_h && !lu_h);
      eb = mp_h || lu_h;
      mb = mx_h || wx_h;
      ws = wx_h;
      cc = bus.E_icode == 4'h6 && !mx_h && !wx_h;
    end
    c = sat(m_cyc, 32); r = sat(m_ret, 32); l = sat(m_lu, 32); p = sat(m_mp, 32);
    c4 = sat(m_cyc, 4); r4 = sat(m_ret, 4); l4 = sat(m_lu, 4); p4 = sat(m_mp, 4);
    return {f, ds, db, eb, mb, ws, cc, (m_st == M_RUN), (m_st == M_HALT), m_fin,
            c, r, l, p, c4[3:0], r4[3:0], l4[3:0], p4[3:0]};
  endfunction

  task automatic model_edge();
    if (m_st == M_RUN) begin
      m_cyc++;
      if (bus.W_stat == 4'h1 && bus.W_icode != 4'h1) m_ret++;
      if (h_lu()) m_lu++;
      if (h_mp()) m_mp++;
      if (is_exc(bus.W_stat)) begin
        m_st  = M_HALT;
        m_fin = bus.W_stat;
      end
    end else if (m_st == M_IDLE && bus.start) begin
      m_st = M_RUN;
    end
  endtask

  // One cycle: inputs already driven; predict, push, advance through the edge.
  task automatic step();
    if (!rst_n) model_reset();
    exp_q.push_back(predict());
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic set_nop();
    bus.start = 0;
    bus.D_icode = 4'h1; bus.E_icode = 4'h1; bus.M_icode = 4'h1; bus.W_icode = 4'h1;
    bus.d_srcA = 4'hF; bus.d_srcB = 4'hF; bus.E_dstM = 4'hF; bus.e_Cnd = 0;
    bus.m_stat = 4'h1; bus.W_stat = 4'h1;
  endtask

  task automatic rand_inputs(input int wx_odds);
    logic [3:0] hot[6];
    hot = '{4'h5, 4'hB, 4'h7, 4'h9, 4'h6, 4'h0};
    bus.start   = 1'($urandom_range(0, 1));
    bus.D_icode = 4'($urandom_range(0, 11));
    bus.E_icode = ($urandom_range(0, 1) == 0) ? hot[$urandom_range(0, 5)] : 4'($urandom_range(0, 11));
    bus.M_icode = 4'($urandom_range(0, 11));
    bus.W_icode = 4'($urandom_range(0, 11));
    bus.d_srcA  = 4'($urandom_range(0, 15));
    bus.d_srcB  = 4'($urandom_range(0, 15));
    bus.E_dstM  = ($urandom_range(0, 2) == 0) ? bus.d_srcA : 4'($urandom_range(0, 15));
    bus.e_Cnd   = 1'($urandom_range(0, 1));
    bus.m_stat  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 5)) : 4'h1;
    if (wx_odds > 0 && $urandom_range(1, wx_odds) == 1) bus.W_stat = 4'($urandom_range(2, 4));
    else if ($urandom_range(0, 7) == 0) bus.W_stat = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h5;
    else bus.W_stat = 4'h1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("F_stall",    32'(bus.F_stall),    32'(e[156]));
      chk("D_stall",    32'(bus.D_stall),    32'(e[155]));
      chk("D_bubble",   32'(bus.D_bubble),   32'(e[154]));
      chk("E_bubble",   32'(bus.E_bubble),   32'(e[153]));
      chk("M_bubble",   32'(bus.M_bubble),   32'(e[152]));
      chk("W_stall",    32'(bus.W_stall),    32'(e[151]));
      chk("set_cc_en",  32'(bus.set_cc_en),  32'(e[150]));
      chk("running",    32'(bus.running),    32'(e[149]));
      chk("halted",     32'(bus.halted),     32'(e[148]));
      chk("final_stat", 32'(bus.final_stat), 32'(e[147:144]));
      chk("cyc_cnt",    bus.cyc_cnt,         e[143:112]);
      chk("ret_cnt",    bus.ret_cnt,         e[111:80]);
      chk("lu_cnt",     bus.lu_cnt,          e[79:48]);
      chk("mp_cnt",     bus.mp_cnt,          e[47:16]);
      chk("cyc_cnt4",   32'(bus4.cyc_cnt),   32'(e[15:12]));
      chk("ret_cnt4",   32'(bus4.ret_cnt),   32'(e[11:8]));
      chk("lu_cnt4",    32'(bus4.lu_cnt),    32'(e[7:4]));
      chk("mp_cnt4",    32'(bus4.mp_cnt),    32'(e[3:0]));
    end
  end

  initial begin
    rst_n = 1'b0;
    set_nop();
    model_reset();
    @(posedge clk); #1;
    step(); step();

    // Idle with noise on the inputs but no start.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_inputs(0); bus.start = 0; step();
    end
    set_nop(); bus.start = 1; step();
    bus.start = 0; step(); step();

    // Load/use held three cycles.
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    step(); step(); step();

    // RET walking D -> E -> M, then RET in M together with a load/use.
    set_nop(); bus.D_icode = 4'h9; step();
    bus.D_icode = 4'h1; bus.E_icode = 4'h9; step();
    bus.E_icode = 4'h1; bus.M_icode = 4'h9; step();
    bus.E_icode = 4'hB; bus.E_dstM = 4'h4; bus.d_srcB = 4'h4; step();

    // Mispredict, then a taken branch.
    set_nop(); bus.E_icode = 4'h7; bus.e_Cnd = 0; step();
    bus.e_Cnd = 1; step();
    set_nop(); bus.W_icode = 4'h6; step();

    for (int i = 0; i < 300; i++) begin
      rand_inputs(0); step();
    end

    // Exception drain into HALTED, then frozen with start asserted.
    set_nop(); bus.E_icode = 4'h6; bus.m_stat = 4'h3; step();
    set_nop(); bus.E_icode = 4'h6; bus.W_stat = 4'h3; step();
    for (int i = 0; i < 10; i++) begin
      rand_inputs(4); bus.start = 1; step();
    end

    // Asynchronous reset out of HALTED, then several runs each ended by exception or reset.
    rst_n = 1'b0; set_nop(); step();
    rst_n = 1'b1; step();
    for (int r = 0; r < 4; r++) begin
      set_nop(); bus.start = 1; step();
      for (int i = 0; i < 60; i++) begin
        rand_inputs(30); step();
      end
      rst_n = 1'b0; rand_inputs(0); step();
      rst_n = 1'b1; set_nop(); step();
    end

    @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
